// File: rtl/exp_bus_arbiter_pkg.sv
// Shared types and constants for the two-master expansion register bus arbiter.
package exp_bus_arbiter_pkg;

    localparam int DW = 16;

`ifndef EXP_NUM_REGS
`define EXP_NUM_REGS 16
`endif
    localparam int EXP_NUM_REGS_DEFAULT = `EXP_NUM_REGS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

endpackage

// File: rtl/exp_bus_arbiter_rr_grant2.sv
// Two-way round-robin grant with a critical-section lock that pins ownership to master 0.
module rr_grant2 (
    input  logic [1:0] i_req,
    input  logic       i_owner,
    input  logic       i_lock,
    output logic       o_grant_idx,
    output logic       o_grant_vld
);

    always_comb begin
        o_grant_idx = 1'b0;
        o_grant_vld = 1'b0;
        // While master 0 holds the lock, master 1 is shut out even if master 0 is idle.
        if (i_lock && !i_owner) begin
            o_grant_vld = i_req[0];
        end else if (&i_req) begin
            o_grant_vld = 1'b1;
            o_grant_idx = ~i_owner;
        end else if (i_req[0]) begin
            o_grant_vld = 1'b1;
        end else if (i_req[1]) begin
            o_grant_vld = 1'b1;
            o_grant_idx = 1'b1;
        end
    end

endmodule

// File: rtl/exp_bus_arbiter.sv
// Arbitrates two masters onto a bank of expansion registers with fixed 3-cycle accesses.
// state  | meaning
// IDLE   | waiting for a request; grant and latch the winner's access
// STROBE | one-cycle register load/read strobe; read data captured
// ACK    | one-cycle completion pulse to the granted master
module exp_bus_arbiter
    import exp_bus_arbiter_pkg::*;
#(
    parameter int NUM_REGS = EXP_NUM_REGS_DEFAULT,
    parameter int AW       = 8
) (
    input  logic                   sysclk,
    input  logic                   sysreset,
    input  logic                   m0_req,
    input  logic                   m0_write,
    input  logic [AW-1:0]          m0_addr,
    input  logic [DW-1:0]          m0_wdata,
    output logic                   m0_ack,
    output logic [DW-1:0]          m0_rdata,
    input  logic                   m0_lock,
    input  logic                   m1_req,
    input  logic                   m1_write,
    input  logic [AW-1:0]          m1_addr,
    input  logic [DW-1:0]          m1_wdata,
    output logic                   m1_ack,
    output logic [DW-1:0]          m1_rdata,
    input  logic [NUM_REGS*DW-1:0] s_r,
    output logic [NUM_REGS-1:0]    s_r_load,
    output logic [NUM_REGS-1:0]    s_r_read,
    output logic [DW-1:0]          s_r_load_data,
    output logic                   owner,
    output logic                   busy,
    output logic                   addr_err
);

    // Compare width wide enough to hold both any address and NUM_REGS itself.
    localparam int XW = (AW > 9) ? AW : 9;

    state_t        r_state;
    logic          r_mst;
    logic          r_write;
    logic          r_oor;
    logic          r_owner;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_m0_rdata;
    logic [DW-1:0] r_m1_rdata;

    logic          w_gnt_idx;
    logic          w_gnt_vld;
    logic [AW-1:0] w_win_addr;
    logic          w_win_oor;
    logic [DW-1:0] w_sel_rdata;
    logic [DW-1:0] w_cap;
    logic          w_strobe;
    logic          w_ack;

    rr_grant2 u_grant (
        .i_req       ({m1_req, m0_req}),
        .i_owner     (r_owner),
        .i_lock      (m0_lock),
        .o_grant_idx (w_gnt_idx),
        .o_grant_vld (w_gnt_vld)
    );

    assign w_win_addr = w_gnt_idx ? m1_addr : m0_addr;
    assign w_win_oor  = XW'(w_win_addr) >= XW'(NUM_REGS);

    always_comb begin
        w_sel_rdata = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (XW'(r_addr) == XW'(k)) begin
                w_sel_rdata = s_r[k*DW +: DW];
            end
        end
    end

    assign w_cap = (r_write || r_oor) ? '0 : w_sel_rdata;

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            r_state    <= ST_IDLE;
            r_mst      <= 1'b0;
            r_write    <= 1'b0;
            r_oor      <= 1'b0;
            r_owner    <= 1'b1;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        r_state <= ST_STROBE;
                        r_mst   <= w_gnt_idx;
                        r_owner <= w_gnt_idx;
                        r_write <= w_gnt_idx ? m1_write : m0_write;
                        r_wdata <= w_gnt_idx ? m1_wdata : m0_wdata;
                        r_addr  <= w_win_addr;
                        r_oor   <= w_win_oor;
                    end
                end
                ST_STROBE: begin
                    r_state <= ST_ACK;
                    if (r_mst) begin
                        r_m1_rdata <= w_cap;
                    end else begin
                        r_m0_rdata <= w_cap;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are gated by sysreset so an aborted transfer shows nothing in the reset cycle.
    assign w_strobe = (r_state == ST_STROBE) && !r_oor && !sysreset;
    assign w_ack    = (r_state == ST_ACK) && !sysreset;

    always_comb begin
        s_r_load = '0;
        s_r_read = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_strobe && (XW'(r_addr) == XW'(k))) begin
                if (r_write) begin
                    s_r_load[k] = 1'b1;
                end else begin
                    s_r_read[k] = 1'b1;
                end
            end
        end
    end

    assign s_r_load_data = (w_strobe && r_write) ? r_wdata : '0;
    assign m0_ack        = w_ack && !r_mst;
    assign m1_ack        = w_ack && r_mst;
    assign m0_rdata      = sysreset ? '0 : r_m0_rdata;
    assign m1_rdata      = sysreset ? '0 : r_m1_rdata;
    assign owner         = sysreset || r_owner;
    assign busy          = (r_state != ST_IDLE) && !sysreset;
    assign addr_err      = w_ack && r_oor;

endmodule
